// File: rtl/dxl_pkg.sv
// Shared constants and packet-state encoding for the Dynamixel protocol 1.0 responder.
package dxl_pkg;

    localparam logic [7:0] INS_PING     = 8'h01;
    localparam logic [7:0] INS_READ     = 8'h02;
    localparam logic [7:0] INS_WRITE    = 8'h03;

    localparam logic [7:0] ERR_NONE     = 8'h00;
    localparam logic [7:0] ERR_RANGE    = 8'h08;
    localparam logic [7:0] ERR_CHKSUM   = 8'h10;
    localparam logic [7:0] ERR_INSTR    = 8'h40;

    localparam logic [7:0] ADDR_ID      = 8'd3;
    localparam logic [7:0] ADDR_LED     = 8'd25;
    localparam logic [7:0] ADDR_GOAL_L  = 8'd30;
    localparam logic [7:0] RW_BASE      = 8'd24;

    localparam logic [7:0] BROADCAST_ID = 8'hFE;
    localparam logic [7:0] HDR_BYTE     = 8'hFF;
    localparam logic [7:0] ADDR0_RESET  = 8'h0C;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR2, S_ID, S_LEN, S_INSTR, S_PARAM, S_CHK, S_EXEC, S_DELAY,
        S_TX_HDR1, S_TX_HDR2, S_TX_ID, S_TX_LEN, S_TX_ERR, S_TX_PARAM, S_TX_CHK
    } pkt_state_t;

endpackage

// File: rtl/dxl_uart_byte.sv
// 8N1 UART byte engine: mid-bit sampling receiver and a transmitter whose done strobe
// lines up with the last stop-bit cycle so the next byte can follow without a gap.
module dxl_uart_byte #(
    parameter int unsigned CLKS_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rxd,
    input  logic       i_rx_en,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_ferr,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_txd
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    logic [1:0]    r_rx_sync;
    logic          r_rx_prev, r_rx_busy, r_rx_valid, r_rx_ferr;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          w_rx;

    assign w_rx = r_rx_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_sync  <= '1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], i_rxd};
            r_rx_prev  <= w_rx;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!i_rx_en) begin
                r_rx_busy <= 1'b0;
            end else if (!r_rx_busy) begin
                if (r_rx_prev && !w_rx) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= CW'(HALF - 1);
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - CW'(1);
            end else begin
                r_rx_cnt <= CW'(CLKS_PER_BIT - 1);
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    // A start bit that is high again at mid-bit was a glitch
                    if (w_rx) r_rx_busy <= 1'b0;
                end else if (r_rx_bit < 4'd9) begin
                    r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                end else begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= w_rx;
                    r_rx_ferr  <= !w_rx;
                end
            end
        end
    end

    assign o_rx_valid = r_rx_valid;
    assign o_rx_ferr  = r_rx_ferr;
    assign o_rx_data  = r_rx_shift;

    logic          r_tx_busy, r_txd;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [8:0]    r_tx_shift;

    assign o_tx_done = r_tx_busy && (r_tx_cnt == '0) && (r_tx_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_busy  <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
        end else if (i_tx_start) begin
            r_tx_busy  <= 1'b1;
            r_txd      <= 1'b0;
            r_tx_shift <= {1'b1, i_tx_data};
            r_tx_cnt   <= CW'(CLKS_PER_BIT - 1);
            r_tx_bit   <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - CW'(1);
            end else if (r_tx_bit == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_txd     <= 1'b1;
            end else begin
                r_txd      <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bit   <= r_tx_bit + 4'd1;
                r_tx_cnt   <= CW'(CLKS_PER_BIT - 1);
            end
        end
    end

    assign o_tx_busy = r_tx_busy;
    assign o_txd     = r_txd;

endmodule

// File: rtl/dynamixel_responder.sv
// Single Dynamixel 1.0 servo model: parses instruction packets, runs PING/READ/WRITE
// against a small control table and answers with a status packet after a turnaround delay.
module dynamixel_responder
    import dxl_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 1_000_000,
    parameter logic [7:0]  SERVO_ID     = 8'h01,
    parameter int unsigned TABLE_DEPTH  = 32,
    parameter int unsigned MAX_PARAMS   = 8,
    parameter int unsigned RETURN_DELAY = 100,
    parameter int unsigned TIMEOUT      = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    output logic        dir,
    output logic [7:0]  led_reg,
    output logic [15:0] goal_pos,
    output logic        pkt_ok,
    output logic        pkt_err
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned AW = $clog2(TABLE_DEPTH);
    localparam int unsigned IW = $clog2(MAX_PARAMS);
    localparam int unsigned PW = $clog2(MAX_PARAMS + 1);
    localparam int unsigned DW = $clog2(RETURN_DELAY + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 2);
    localparam logic [8:0]    DEPTH9   = 9'(TABLE_DEPTH);
    localparam logic [7:0]    MAXP8    = 8'(MAX_PARAMS);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_PARAMS + 2);
    localparam logic [DW-1:0] DLY_LAST = DW'(RETURN_DELAY - 1);
    localparam logic [TW-1:0] TOUT_T   = TW'(TIMEOUT);

    pkt_state_t    r_state, w_state_nxt;
    logic [7:0]    r_id, r_len, r_instr, r_sum, r_err, r_rd_addr, r_tx_sum;
    logic [7:0]    r_params [MAX_PARAMS];
    logic [7:0]    r_table  [TABLE_DEPTH];
    logic [PW-1:0] r_pcnt, r_resp_n, r_tx_idx;
    logic [DW-1:0] r_dly;
    logic [TW-1:0] r_tout;
    logic          r_chk_ok, r_dir, r_pkt_ok, r_pkt_err;

    logic          w_rx_valid, w_rx_ferr, w_tx_busy, w_tx_done;
    logic [7:0]    w_rx_data;
    logic          w_tx_start, w_ok_pulse, w_err_pulse;
    logic [7:0]    w_tx_byte;

    dxl_uart_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk        (clk),
        .reset      (reset),
        .i_rxd      (rxd),
        .i_rx_en    (!r_dir),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_rx_ferr  (w_rx_ferr),
        .i_tx_start (w_tx_start),
        .i_tx_data  (w_tx_byte),
        .o_tx_busy  (w_tx_busy),
        .o_tx_done  (w_tx_done),
        .o_txd      (txd)
    );

    logic       w_own, w_bcast, w_in_rx, w_tout_hit, w_do_write;
    logic [7:0] w_nparam, w_addr, w_cnt, w_nd, w_err, w_rd_byte;
    logic [8:0] w_rd_end, w_wr_end;
    logic [PW-1:0] w_resp_n;

    assign w_own      = (r_id == SERVO_ID);
    assign w_bcast    = (r_id == BROADCAST_ID);
    assign w_in_rx    = r_state inside {S_HDR2, S_ID, S_LEN, S_INSTR, S_PARAM, S_CHK};
    assign w_tout_hit = (r_tout > TOUT_T);
    assign w_nparam   = r_len - 8'd2;
    assign w_addr     = r_params[0];
    assign w_cnt      = r_params[1];
    assign w_nd       = w_nparam - 8'd1;
    assign w_rd_end   = {1'b0, w_addr} + {1'b0, w_cnt};
    assign w_wr_end   = {1'b0, w_addr} + {1'b0, w_nd};
    assign w_rd_byte  = r_table[AW'(r_rd_addr + 8'(r_tx_idx))];

    always_comb begin
        w_err      = ERR_NONE;
        w_resp_n   = '0;
        w_do_write = 1'b0;
        if (!r_chk_ok) begin
            w_err = ERR_CHKSUM;
        end else begin
            case (r_instr)
                INS_PING: ;
                INS_READ:
                    if (w_nparam < 8'd2 || w_rd_end > DEPTH9 || w_cnt > MAXP8) w_err = ERR_RANGE;
                    else w_resp_n = PW'(w_cnt);
                INS_WRITE:
                    if (w_nparam < 8'd2 || w_addr < RW_BASE || w_wr_end > DEPTH9) w_err = ERR_RANGE;
                    else w_do_write = 1'b1;
                default: w_err = ERR_INSTR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        w_tx_byte   = HDR_BYTE;
        w_ok_pulse  = 1'b0;
        w_err_pulse = 1'b0;
        case (r_state)
            S_IDLE:  if (w_rx_valid && w_rx_data == HDR_BYTE) w_state_nxt = S_HDR2;
            S_HDR2:  if (w_rx_valid) w_state_nxt = (w_rx_data == HDR_BYTE) ? S_ID : S_IDLE;
            S_ID:    if (w_rx_valid && w_rx_data != HDR_BYTE) w_state_nxt = S_LEN;
            S_LEN:
                if (w_rx_valid) begin
                    if (w_rx_data < 8'd2 || w_rx_data > LEN_MAX) begin
                        w_state_nxt = S_IDLE;
                        w_err_pulse = 1'b1;
                    end else begin
                        w_state_nxt = S_INSTR;
                    end
                end
            S_INSTR: if (w_rx_valid) w_state_nxt = (r_len == 8'd2) ? S_CHK : S_PARAM;
            S_PARAM: if (w_rx_valid && (8'(r_pcnt) + 8'd1 == w_nparam)) w_state_nxt = S_CHK;
            S_CHK:   if (w_rx_valid) w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_ok_pulse  = (w_err == ERR_NONE) && (w_own || (w_bcast && r_instr == INS_WRITE));
                w_err_pulse = !r_chk_ok && (w_own || w_bcast);
                w_state_nxt = w_own ? S_DELAY : S_IDLE;
            end
            S_DELAY:
                if (r_dly >= DLY_LAST && !w_tx_busy) begin
                    w_state_nxt = S_TX_HDR1;
                    w_tx_start  = 1'b1;
                end
            S_TX_HDR1: if (w_tx_done) begin w_state_nxt = S_TX_HDR2; w_tx_start = 1'b1; end
            S_TX_HDR2:
                if (w_tx_done) begin w_state_nxt = S_TX_ID; w_tx_start = 1'b1; w_tx_byte = r_id; end
            S_TX_ID:
                if (w_tx_done) begin
                    w_state_nxt = S_TX_LEN;
                    w_tx_start  = 1'b1;
                    w_tx_byte   = 8'(r_resp_n) + 8'd2;
                end
            S_TX_LEN:
                if (w_tx_done) begin w_state_nxt = S_TX_ERR; w_tx_start = 1'b1; w_tx_byte = r_err; end
            S_TX_ERR, S_TX_PARAM:
                // r_tx_idx points at the next data byte still to be sent
                if (w_tx_done) begin
                    w_tx_start = 1'b1;
                    if (r_tx_idx < r_resp_n) begin
                        w_state_nxt = S_TX_PARAM;
                        w_tx_byte   = w_rd_byte;
                    end else begin
                        w_state_nxt = S_TX_CHK;
                        w_tx_byte   = ~r_tx_sum;
                    end
                end
            S_TX_CHK: if (w_tx_done) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_in_rx && (w_rx_ferr || w_tout_hit)) begin
            w_state_nxt = S_IDLE;
            w_err_pulse = w_tout_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id <= '0; r_len <= '0; r_instr <= '0; r_sum <= '0; r_err <= '0;
            r_rd_addr <= '0; r_tx_sum <= '0; r_pcnt <= '0; r_resp_n <= '0;
            r_tx_idx <= '0; r_dly <= '0; r_tout <= '0; r_chk_ok <= 1'b0;
            r_dir <= 1'b0; r_pkt_ok <= 1'b0; r_pkt_err <= 1'b0;
            for (int unsigned i = 0; i < MAX_PARAMS; i++) r_params[i] <= '0;
            for (int unsigned i = 0; i < TABLE_DEPTH; i++) r_table[i] <= '0;
            r_table[0]           <= ADDR0_RESET;
            r_table[AW'(ADDR_ID)] <= SERVO_ID;
        end else begin
            r_dir     <= w_state_nxt inside {S_TX_HDR1, S_TX_HDR2, S_TX_ID, S_TX_LEN,
                                             S_TX_ERR, S_TX_PARAM, S_TX_CHK};
            r_pkt_ok  <= w_ok_pulse;
            r_pkt_err <= w_err_pulse;
            r_tout    <= (w_rx_valid || !w_in_rx) ? '0 : r_tout + TW'(1);
            if (w_rx_valid) begin
                case (r_state)
                    S_ID:    if (w_rx_data != HDR_BYTE) begin r_id <= w_rx_data; r_sum <= w_rx_data; end
                    S_LEN:   begin r_len <= w_rx_data; r_sum <= r_sum + w_rx_data; end
                    S_INSTR: begin r_instr <= w_rx_data; r_sum <= r_sum + w_rx_data; r_pcnt <= '0; end
                    S_PARAM: begin
                        r_params[IW'(r_pcnt)] <= w_rx_data;
                        r_sum  <= r_sum + w_rx_data;
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                    S_CHK:   r_chk_ok <= (w_rx_data == ~r_sum);
                    default: ;
                endcase
            end
            if (r_state == S_EXEC) begin
                r_err     <= w_err;
                r_resp_n  <= w_resp_n;
                r_rd_addr <= w_addr;
                r_tx_idx  <= '0;
                r_tx_sum  <= r_id + 8'(w_resp_n) + 8'd2 + w_err;
                r_dly     <= '0;
                if (w_do_write && (w_own || w_bcast))
                    for (int unsigned i = 0; i < MAX_PARAMS - 1; i++)
                        if (8'(i) < w_nd) r_table[AW'(w_addr + 8'(i))] <= r_params[IW'(i + 1)];
            end
            if (r_state == S_DELAY) r_dly <= r_dly + DW'(1);
            if (w_tx_start && w_state_nxt == S_TX_PARAM) begin
                r_tx_sum <= r_tx_sum + w_tx_byte;
                r_tx_idx <= r_tx_idx + PW'(1);
            end
        end
    end

    assign dir      = r_dir;
    assign pkt_ok   = r_pkt_ok;
    assign pkt_err  = r_pkt_err;
    assign led_reg  = r_table[AW'(ADDR_LED)];
    assign goal_pos = {r_table[AW'(ADDR_GOAL_L + 8'd1)], r_table[AW'(ADDR_GOAL_L)]};

endmodule

// File: tb/tb_dynamixel_responder.sv
// Directed bench: drives instruction packets onto rxd, decodes txd with a UART monitor and
// compares status bytes, table outputs and pulse counts against hand-computed values.
module tb_dynamixel_responder;
    localparam int unsigned CPB  = 10;
    localparam int unsigned TOUT = 400;

    logic        clk = 1'b0, reset = 1'b1, rxd = 1'b1;
    logic        txd, dir, pkt_ok, pkt_err;
    logic [7:0]  led_reg;
    logic [15:0] goal_pos;

    dynamixel_responder #(
        .CLK_FREQ(50_000_000), .BAUD(5_000_000), .SERVO_ID(8'h01),
        .TABLE_DEPTH(32), .MAX_PARAMS(8), .RETURN_DELAY(100), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .dir(dir),
        .led_reg(led_reg), .goal_pos(goal_pos), .pkt_ok(pkt_ok), .pkt_err(pkt_err)
    );

    always #10 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int ok_cnt = 0, err_cnt = 0, dir_rise = 0, dir_bad = 0;
    int ok0, err0, rise0;
    logic dir_d = 1'b0;
    logic [7:0] mon_q[$];
    logic [7:0] pkt[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (pkt_ok === 1'b1) ok_cnt++;
        if (pkt_err === 1'b1) err_cnt++;
        if (dir === 1'b1 && dir_d !== 1'b1) dir_rise++;
        dir_d = dir;
    end

    always @(negedge clk) if (txd === 1'b0 && dir !== 1'b1) dir_bad++;

    always begin : monitor
        logic [7:0] b;
        @(negedge txd);
        repeat (CPB / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b[i] = txd;
        end
        repeat (CPB) @(posedge clk);
        mon_q.push_back(b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic mark();
        ok0 = ok_cnt; err0 = err_cnt; rise0 = dir_rise;
    endtask

    task automatic expect_resp(input string tag);
        int c = 0;
        while (mon_q.size() < exp_q.size() && c < 5000) begin
            @(posedge clk);
            c++;
        end
        repeat (20) @(posedge clk);
        check({tag, "_nbytes"}, 32'(mon_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (i < mon_q.size()) check($sformatf("%s_b%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
        @(negedge clk);
        check({tag, "_dir_low"}, 32'(dir), 32'd0);
        check({tag, "_dir_rise"}, 32'(dir_rise - rise0), 32'd1);
        mon_q.delete();
    endtask

    task automatic expect_none(input string tag);
        repeat (1500) @(posedge clk);
        check({tag, "_no_tx"}, 32'(mon_q.size()), 32'd0);
        check({tag, "_no_dir"}, 32'(dir_rise - rise0), 32'd0);
        mon_q.delete();
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_led", 32'(led_reg), 32'd0);
        check("rst_goal", 32'(goal_pos), 32'd0);
        check("rst_ok", 32'(pkt_ok), 32'd0);
        check("rst_err", 32'(pkt_err), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, 8'hFB}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}; expect_resp("ping");
        check("ping_ok", 32'(ok_cnt - ok0), 32'd1);

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h03, 8'h19, 8'h01, 8'hDD}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}; expect_resp("wr_led");
        check("wr_led_val", 32'(led_reg), 32'h01);
        check("wr_led_ok", 32'(ok_cnt - ok0), 32'd1);

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h02, 8'h19, 8'h01, 8'hDE}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h01, 8'hFA}; expect_resp("rd_led");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h05, 8'h03, 8'h1E, 8'h34, 8'h12, 8'h92}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}; expect_resp("wr_goal");
        check("wr_goal_val", 32'(goal_pos), 32'h1234);

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, 8'h00}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h10, 8'hEC}; expect_resp("badchk");
        check("badchk_err", 32'(err_cnt - err0), 32'd1);
        check("badchk_ok", 32'(ok_cnt - ok0), 32'd0);

        mark(); pkt = '{8'hFF, 8'hFF, 8'h02, 8'h02, 8'h01, 8'hFA}; send_pkt();
        expect_none("foreign");

        mark(); pkt = '{8'hFF, 8'hFF, 8'hFE, 8'h04, 8'h03, 8'h19, 8'h02, 8'hDF}; send_pkt();
        expect_none("bcast");
        check("bcast_led", 32'(led_reg), 32'h02);

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h03, 8'h03, 8'h05, 8'hEF}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h08, 8'hF4}; expect_resp("wr_ro");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h02, 8'h03, 8'h01, 8'hF4}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h01, 8'hFA}; expect_resp("rd_id");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h02, 8'h00, 8'h01, 8'hF7}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h0C, 8'hEF}; expect_resp("rd_addr0");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h02, 8'h1F, 8'h02, 8'hD7}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h08, 8'hF4}; expect_resp("rd_range");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h05, 8'hF7}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h40, 8'hBC}; expect_resp("bad_instr");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h0B}; send_pkt();
        repeat (50) @(posedge clk);
        check("len_err", 32'(err_cnt - err0), 32'd1);
        expect_none("len_err");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01}; send_pkt();
        repeat (TOUT + 10) @(posedge clk);
        check("timeout_err", 32'(err_cnt - err0), 32'd1);
        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, 8'hFB}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}; expect_resp("ping_after_tout");

        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, 8'hFB}; send_pkt();
        for (int c = 0; c < 3000 && mon_q.size() < 4; c++) @(posedge clk);
        check("midtx_reached", 32'(mon_q.size() >= 4), 32'd1);
        repeat (20) @(posedge clk);
        check("midtx_dir_high", 32'(dir), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("midtx_txd", 32'(txd), 32'd1);
        check("midtx_dir", 32'(dir), 32'd0);
        check("midtx_led", 32'(led_reg), 32'd0);
        check("midtx_goal", 32'(goal_pos), 32'd0);
        reset = 1'b0;
        repeat (300) @(posedge clk);
        mon_q.delete();
        mark(); pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, 8'hFB}; send_pkt();
        exp_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC}; expect_resp("ping_after_rst");

        check("dir_covers_tx", 32'(dir_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dynamixel_responder.md
Name: dynamixel_responder

Overview:
Emulates one Dynamixel servo (protocol 1.0) on a half-duplex UART line. It is the responder to the UART_Dynamixel initiator: it receives instruction packets, validates them, executes PING/READ/WRITE against a small control table, and returns status packets. It is used on GPIO_1 as a loopback target for hardware bring-up, and as the servo model in the initiator's testbench.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz.
BAUD, 1_000_000, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, which is 50 at the defaults.
SERVO_ID, 8'h01, own ID. 8'hFE is always the broadcast ID.
TABLE_DEPTH, 32, number of control-table bytes (addresses 0..TABLE_DEPTH-1).
MAX_PARAMS, 8, maximum number of parameter bytes buffered from one packet.
RETURN_DELAY, 100, idle cycles between the checksum stop bit and the status start bit.
TIMEOUT, 5000, maximum cycles between two bytes inside one packet.

Ports:
clk  in  1  system clock (CLOCK_50).
reset  in  1  synchronous, active-high reset.
rxd  in  1  UART receive line, 8N1, idle high.
txd  out  1  UART transmit line, 8N1, idle high.
dir  out  1  1 = responder drives the bus. The top level inverts it for the buffer enable.
led_reg  out  8  control-table byte at address 25.
goal_pos  out  16  bytes at addresses 31:30, little-endian.
pkt_ok  out  1  one-cycle pulse after a valid packet addressed to this servo has been executed.
pkt_err  out  1  one-cycle pulse on a checksum error, a length error or a timeout.

Behaviour:
- Reset values:
  - txd=1, dir=0, pkt_ok=0, pkt_err=0.
  - FSM goes to IDLE and the parameter buffer is cleared.
  - Control table reloads defaults: addr0=8'h0C, addr3=SERVO_ID, all other bytes 0. So led_reg=0 and goal_pos=0.
- Reset mid-operation: aborts RX or TX immediately. txd returns high the next cycle, with no partial frame.
- UART byte engine:
  - RX: start bit detected on the falling edge, sampled at CLKS_PER_BIT/2. Data bits are sampled every CLKS_PER_BIT, LSB first.
  - Framing error (stop bit = 0): the byte is discarded and the FSM goes to IDLE.
  - TX: start bit, 8 data bits LSB first, stop bit, each bit exactly CLKS_PER_BIT cycles.
- Packet FSM states: IDLE, HDR2, ID, LEN, INSTR, PARAM, CHK, EXEC, DELAY, TX_HDR1, TX_HDR2, TX_ID, TX_LEN, TX_ERR, TX_PARAM, TX_CHK.
- Header and field rules:
  - IDLE→HDR2 on byte FF. HDR2→ID on FF; any other byte returns to IDLE.
  - ID byte FF keeps the FSM in ID, so a run of FF bytes is tolerated.
  - LEN must be in 2..MAX_PARAMS+2. A LEN outside that range pulses pkt_err and returns to IDLE.
  - PARAM stores LEN-2 bytes in the buffer.
- Checksum: ~(ID+LEN+INSTR+Σparams), computed mod 256.
- Addressing:
  - ID≠SERVO_ID and ID≠FE: the packet is parsed and checked, then discarded. No response; dir stays 0.
  - ID=FE: WRITE is executed with no response. PING and READ are ignored.
- Checksum mismatch on own ID: pkt_err pulses, no table change, status sent with ERR=8'h10.
- EXEC: commits atomically, only after the checksum is valid.
  - PING (01): no table access.
  - READ (02), params addr,n: if addr+n > TABLE_DEPTH or n > MAX_PARAMS, ERR=8'h08 and no data bytes. Otherwise n data bytes are returned.
  - WRITE (03), params addr,d0..: addresses below 24 are read-only. Any write touching them, or running past TABLE_DEPTH, gives ERR=8'h08 and writes no byte. Otherwise all bytes are written in a single cycle.
  - Any other instruction: ERR=8'h40.
  - pkt_ok pulses in EXEC only when ERR=0.
- Status packet: FF FF ID LEN ERR [data] CHK, with LEN = n+2.
- Turnaround:
  - DELAY counts RETURN_DELAY cycles.
  - dir rises in the same cycle the TX_HDR1 start bit begins.
  - dir falls in the cycle after the TX_CHK stop bit completes.
- While dir=1, rxd is ignored.
- Inter-byte timeout: in HDR2..CHK, more than TIMEOUT cycles between two stop bits pulses pkt_err and returns to IDLE.
- Output timing: led_reg and goal_pos are registered and update the cycle after EXEC.

Decomposition:
- Package dxl_pkg:
  - instruction codes (INS_PING, INS_READ, INS_WRITE);
  - error bits (ERR_RANGE=08, ERR_CHKSUM=10, ERR_INSTR=40);
  - table addresses (ADDR_ID=3, ADDR_LED=25, ADDR_GOAL_L=30, RW_BASE=24);
  - BROADCAST_ID;
  - the packet-state enum.
- Sub-module dxl_uart_byte: RX and TX byte engine with CLKS_PER_BIT as a parameter.
  - RX interface: rx_valid/rx_data/rx_ferr.
  - TX interface: tx_start/tx_data/tx_busy/tx_done.

Test Plan:
1. PING FF FF 01 02 01 FB → after RETURN_DELAY, txd sends FF FF 01 02 00 FC. dir is high only during the frame, and pkt_ok pulses once.
2. WRITE LED FF FF 01 04 03 19 01 DD → led_reg=8'h01 and response FF FF 01 02 00 FC. Then READ FF FF 01 04 02 19 01 DE → response FF FF 01 03 00 01 FA.
3. Bad checksum FF FF 01 02 01 00 → pkt_err pulses and the response is FF FF 01 02 10 EC. A foreign-ID PING FF FF 02 02 01 FA → no txd activity, dir stays 0.
4. Broadcast FF FF FE 04 03 19 01 E0 → led_reg=01 with no response. Then WRITE to read-only address 03 (FF FF 01 04 03 03 05 EF) → ERR=08 and table unchanged.
5. Send FF FF 01, then keep the line idle for TIMEOUT+10 cycles → pkt_err pulses. A following valid PING is answered normally.
6. Assert reset during the TX_ERR byte → txd=1 and dir=0 the next cycle, led_reg=0. A subsequent PING is answered.
